// File: rtl/shoot_sound_player_if.sv
// Stereo Avalon-ST sample link between the shoot-sound player and the codec.
// Both channels carry the same mono sample; each has its own valid/ready.
interface shoot_sound_player_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  left_valid;
  logic                  right_valid;
  logic                  left_ready;
  logic                  right_ready;

  modport master (
    output left_data,
    output right_data,
    output left_valid,
    output right_valid,
    input  left_ready,
    input  right_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  left_valid,
    input  right_valid,
    output left_ready,
    output right_ready
  );
endinterface

// File: rtl/shoot_sound_player.sv
// Tank-shoot sound sequencer: walks the sample ROM once per play pulse,
// attenuates each word and hands it to both codec channels.
module shoot_sound_player #(
  parameter int NUM_SAMPLES = 17000,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic [2:0]            volume,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_chipselect,
  output logic                  rom_clken,
  input  logic [DATA_WIDTH-1:0] rom_readdata,
  shoot_sound_player_if.master  codec,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PRESENT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(NUM_SAMPLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [DATA_WIDTH-1:0] w_sample_nxt;
  logic                  r_lv;
  logic                  w_lv_nxt;
  logic                  r_rv;
  logic                  w_rv_nxt;
  logic                  r_pend;
  logic                  w_pend_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_l_ok;
  logic                  w_r_ok;
  logic                  w_accept;
  logic                  w_last;

  // A dropped valid inside PRESENT means that channel already took the sample.
  assign w_l_ok   = !r_lv || codec.left_ready;
  assign w_r_ok   = !r_rv || codec.right_ready;
  assign w_accept = (r_state == S_PRESENT) && w_l_ok && w_r_ok;
  assign w_last   = (r_addr == LP_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_sample_nxt = r_sample;
    w_lv_nxt     = r_lv;
    w_rv_nxt     = r_rv;
    w_pend_nxt   = r_pend;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (play) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_LATCH;
        if (play) w_pend_nxt = 1'b1;
      end
      S_LATCH: begin
        w_sample_nxt = $signed(rom_readdata) >>> volume;
        w_lv_nxt     = 1'b1;
        w_rv_nxt     = 1'b1;
        w_state_nxt  = S_PRESENT;
        if (play) w_pend_nxt = 1'b1;
      end
      S_PRESENT: begin
        if (w_accept) begin
          w_lv_nxt   = 1'b0;
          w_rv_nxt   = 1'b0;
          w_pend_nxt = 1'b0;
          if (play || r_pend) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_FETCH;
          end else if (w_last) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end else begin
          if (codec.left_ready)  w_lv_nxt = 1'b0;
          if (codec.right_ready) w_rv_nxt = 1'b0;
          if (play) w_pend_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_sample <= '0;
      r_lv     <= 1'b0;
      r_rv     <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_sample <= w_sample_nxt;
      r_lv     <= w_lv_nxt;
      r_rv     <= w_rv_nxt;
      r_pend   <= w_pend_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign rom_address      = r_addr;
  assign rom_chipselect   = reset_n;
  assign rom_clken        = (r_state == S_FETCH);
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign codec.left_data  = r_sample;
  assign codec.right_data = r_sample;
  assign codec.left_valid = r_lv;
  assign codec.right_valid = r_rv;

endmodule

// File: tb/tb_shoot_sound_player.sv
// Randomised bench for shoot_sound_player against a sample-level model.
// The sample count is shortened so several full passes stay quick.
module tb_shoot_sound_player;

  localparam int NS = 1500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic [2:0]  volume = 3'd0;
  logic [14:0] rom_address;
  logic        rom_chipselect;
  logic        rom_clken;
  logic [15:0] rom_readdata;
  logic        busy;
  logic        done;

  logic [15:0] rom [0:32767];

  shoot_sound_player_if #(.DATA_WIDTH(16)) codec ();

  shoot_sound_player #(
    .NUM_SAMPLES(NS),
    .ADDR_WIDTH (15),
    .DATA_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .play          (play),
    .volume        (volume),
    .rom_address   (rom_address),
    .rom_chipselect(rom_chipselect),
    .rom_clken     (rom_clken),
    .rom_readdata  (rom_readdata),
    .codec         (codec.master),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_clken) rom_readdata <= rom[rom_address];

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  // Sample-level model: which sample is due, how many cycles until it is
  // shown, and which channels have taken it.
  bit          m_busy;
  int          m_wait;
  int          m_addr;
  bit          m_la;
  bit          m_ra;
  bit          m_pend;
  bit          m_done;
  logic [15:0] m_exp;

  logic [15:0] obs_l;
  logic [15:0] obs_r;
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, n_cyc);
    end
  endtask

  function automatic bit m_lv();
    return m_busy && m_wait == 0 && !m_la;
  endfunction

  function automatic bit m_rv();
    return m_busy && m_wait == 0 && !m_ra;
  endfunction

  function automatic bit m_presenting(input int a);
    return m_busy && m_wait == 0 && m_addr == a;
  endfunction

  task automatic m_clear();
    m_busy = 0; m_wait = 0; m_addr = 0;
    m_la = 0; m_ra = 0; m_pend = 0; m_done = 0;
  endtask

  task automatic m_step(input bit p, input bit lr, input bit rr);
    bit la, ra;
    m_done = 0;
    if (!m_busy) begin
      if (p) begin
        m_busy = 1; m_wait = 2; m_addr = 0;
        m_la = 0; m_ra = 0; m_pend = 0;
      end
    end else if (m_wait > 0) begin
      if (m_wait == 1) m_exp = $signed(rom[m_addr]) >>> volume;
      m_wait--;
      m_pend |= p;
    end else begin
      la = m_la || lr;
      ra = m_ra || rr;
      if (la && ra) begin
        m_la = 0; m_ra = 0; m_wait = 2;
        if (p || m_pend) begin
          m_addr = 0; m_pend = 0;
        end else if (m_addr == NS - 1) begin
          m_busy = 0; m_done = 1; m_addr = 0;
        end else begin
          m_addr++;
        end
      end else begin
        m_la = la; m_ra = ra;
        m_pend |= p;
      end
    end
  endtask

  task automatic cmp();
    logic [5:0] e, a;
    bit fetch;
    fetch = m_busy && m_wait == 2;
    e = {m_busy, m_lv(), m_rv(), m_done, fetch, 1'b1};
    a = {busy, codec.left_valid, codec.right_valid,
         done, rom_clken, rom_chipselect};
    chk("ctl", 32'(a), 32'(e));
    if (fetch) chk("rom_addr", 32'(rom_address), 32'(m_addr));
    if (m_lv()) chk("ldata", 32'(codec.left_data), 32'(m_exp));
    if (m_rv()) chk("rdata", 32'(codec.right_data), 32'(m_exp));
    obs_l = codec.left_data;
    obs_r = codec.right_data;
  endtask

  task automatic cyc(input bit p, input bit lr, input bit rr);
    play = p;
    codec.left_ready  = lr;
    codec.right_ready = rr;
    @(posedge clk);
    n_cyc++;
    if (m_lv() && lr) q_l.push_back(obs_l);
    if (m_rv() && rr) q_r.push_back(obs_r);
    m_step(p, lr, rr);
    @(negedge clk);
    cmp();
  endtask

  task automatic run_until(input int a, input int lim, input string nm);
    int k = 0;
    while (!m_presenting(a) && k < lim) begin
      cyc(0, 1, 1);
      k++;
    end
    chk(nm, 32'(m_presenting(a)), 1);
  endtask

  task automatic do_reset(input string nm);
    logic [7:0] a;
    reset_n = 1'b0;
    #1;
    a = {busy, codec.left_valid, codec.right_valid, done,
         rom_clken, rom_chipselect,
         rom_address != 0, codec.left_data != 0};
    chk(nm, 32'(a), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_clear();
  endtask

  initial begin
    int p0, fv, td, nd, bad, nb;
    logic [15:0] att [0:2];
    for (int i = 0; i < 32768; i++) rom[i] = 16'(i);
    m_clear();
    codec.left_ready  = 1'b0;
    codec.right_ready = 1'b0;

    // reset held, then idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'({busy, codec.left_valid, codec.right_valid,
                        done, rom_clken, rom_chipselect}), 0);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_data", 32'({codec.left_data, codec.right_data}), 0);
    reset_n = 1'b1;
    #1;
    chk("cs_release", 32'(rom_chipselect), 1);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1'($urandom), 1'($urandom));
      if (codec.left_valid || codec.right_valid || busy) nb++;
    end
    chk("idle_quiet", 32'(nb), 0);

    // full playback, readys tied high
    q_l.delete(); q_r.delete();
    cyc(1, 1, 1);
    p0 = n_cyc; fv = -1; td = -1; nd = 0;
    for (int i = 0; i < 3 * NS + 20; i++) begin
      cyc(0, 1, 1);
      if (fv < 0 && codec.left_valid) fv = n_cyc;
      if (done) begin
        nd++; td = n_cyc;
        chk("busy_at_done", 32'(busy), 0);
      end
    end
    chk("first_valid_t", 32'(fv - p0 + 1), 3);
    chk("done_t", 32'(td - p0 + 1), 32'(3 * NS + 1));
    chk("done_count", 32'(nd), 1);
    chk("left_count", 32'(q_l.size()), NS);
    chk("right_count", 32'(q_r.size()), NS);
    bad = 0;
    foreach (q_l[i]) if (q_l[i] != 16'(i)) bad++;
    foreach (q_r[i]) if (q_r[i] != 16'(i)) bad++;
    chk("seq_order", 32'(bad), 0);

    // attenuation literals
    rom[0] = 16'h8000; rom[1] = 16'h7FFF; rom[2] = 16'h8000;
    att[0] = 'x; att[1] = 'x; att[2] = 'x;
    for (int i = 0; i < 12; i++) begin
      volume = (m_addr == 0) ? 3'd3 : 3'd7;
      cyc(i == 0, 1, 1);
      if (codec.left_valid && m_addr < 3) att[m_addr] = codec.left_data;
    end
    chk("att_8000_v3", 32'(att[0]), 32'h0000F000);
    chk("att_7fff_v7", 32'(att[1]), 32'h000000FF);
    chk("att_8000_v7", 32'(att[2]), 32'h0000FF00);
    do_reset("att_async_rst");
    rom[0] = 16'h0000; rom[1] = 16'h0001; rom[2] = 16'h0002;
    volume = 3'd0;

    // skewed: right ready every 5th cycle
    q_l.delete(); q_r.delete();
    cyc(1, 1, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, ((n_cyc + 1) % 5) == 0);
    bad = 0;
    foreach (q_r[i]) if (q_r[i] != 16'(i)) bad++;
    chk("skew_right_seq", 32'(bad), 0);
    chk("skew_right_n", 32'(q_r.size() > 10), 1);

    // random readys, volume and occasional retrigger
    for (int i = 0; i < 2000; i++) begin
      volume = 3'($urandom);
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom));
    end
    volume = 3'd0;

    // retrigger while presenting sample 100
    cyc(1, 1, 1);
    run_until(0, 200, "reach_0");
    run_until(100, 400, "reach_100");
    q_l.delete();
    cyc(1, 0, 0);
    nd = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1);
      if (done) nd++;
      if (!busy) nb++;
    end
    chk("retrig_len", 32'(q_l.size() >= 2), 1);
    chk("retrig_cur", 32'(q_l[0]), 100);
    chk("retrig_next", 32'(q_l[1]), 0);
    chk("retrig_no_done", 32'(nd), 0);
    chk("retrig_busy", 32'(nb), 0);

    // play coincident with the final accept
    run_until(NS - 1, 3 * NS + 50, "reach_last");
    q_l.delete();
    cyc(1, 1, 1);
    nd = 0; nb = 0;
    if (done) nd++;
    if (!busy) nb++;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1);
      if (done) nd++;
      if (!busy) nb++;
    end
    chk("final_cur", 32'(q_l[0]), 32'(NS - 1));
    chk("final_next", 32'(q_l[1]), 0);
    chk("final_no_done", 32'(nd), 0);
    chk("final_busy", 32'(nb), 0);

    // asynchronous reset mid-playback
    run_until(500, 2000, "reach_500");
    cyc(0, 0, 0);
    do_reset("mid_async_rst");
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1);
      if (busy || codec.left_valid) nb++;
    end
    chk("post_rst_idle", 32'(nb), 0);
    cyc(1, 1, 1);
    chk("restart_fetch", 32'({rom_clken, 15'(rom_address)}), 32'h8000);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
